// File: rtl/jt7759_feeder_pkg.sv
// Shared definitions for the JT7759 slave-mode data feeder.
//  - feed_state_t : bus FSM states (IDLE, FETCH, WAIT_REQ, SETUP, PULSE, HOLD, ACK)
//  - *_DEF        : default parameter values for the feeder top
package jt7759_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_WAIT_REQ = 3'd2,
        ST_SETUP    = 3'd3,
        ST_PULSE    = 3'd4,
        ST_HOLD     = 3'd5,
        ST_ACK      = 3'd6
    } feed_state_t;

    localparam int AW_DEF     = 17;
    localparam int WR_W_DEF   = 4;
    localparam int TOUT_W_DEF = 8;

endpackage

// File: rtl/jt7759_feeder_fetch.sv
// ROM prefetch unit for the JT7759 feeder: keeps a 1-byte buffer filled from
// the sample ROM while the bus FSM waits on the chip.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  load                accept a new transfer (load_addr/load_len sampled)
//  stop                cancel: drop remaining fetches and invalidate the buffer
//  load_addr, load_len first ROM byte and byte count
//  pop                 buffer consumed by the bus FSM
//  rom_cs, rom_addr    ROM request and byte address
//  rom_data, rom_ok    ROM answer
//  buf_data, buf_vld   prefetched byte and its valid flag
module jt7759_feeder_fetch #(
    parameter int AW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          stop,
    input  logic [AW-1:0] load_addr,
    input  logic [AW-1:0] load_len,
    input  logic          pop,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic [7:0]    buf_data,
    output logic          buf_vld
);

    logic [AW-1:0] left;    // bytes not yet fetched
    logic [1:0]    age;     // clk cycles the current request has been stable, saturates at 2
    logic          take;

    assign rom_cs = !buf_vld && (left != '0);
    // An rom_ok seen in the first two cycles of a request may still belong to
    // the previous address, so only a request at least two cycles old is trusted.
    assign take   = rom_cs && rom_ok && (age == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= '0;
            left     <= '0;
            age      <= '0;
            buf_vld  <= 1'b0;
        end else if (stop) begin
            left     <= '0;
            age      <= '0;
            buf_vld  <= 1'b0;
        end else if (load) begin
            rom_addr <= load_addr;
            left     <= load_len;
            age      <= '0;
            buf_vld  <= 1'b0;
        end else if (take) begin
            buf_vld  <= 1'b1;
            rom_addr <= rom_addr + 1'b1;   // wraps modulo 2^AW
            left     <= left - 1'b1;
            age      <= '0;
        end else begin
            if (pop) buf_vld <= 1'b0;
            if (!rom_cs) age <= '0;
            else if (age != 2'd2) age <= age + 2'd1;
        end
    end

    // Data register carries no reset; buf_vld qualifies it.
    always_ff @(posedge clk) begin
        if (take) buf_data <= rom_data;
    end

endmodule

// File: rtl/jt7759_feeder.sv
// Host-side master for the JT7759 slave-mode (mdn=0) data port. Streams a ROM
// region into the chip one byte per drqn request using a cs/wrn write strobe,
// and waits for drqn to return high before offering the next byte.
// Ports:
//  clk, rst        clock, synchronous active-high reset
//  cen             clock enable for bus timing (chip cen_ctl rate)
//  start, abort    transfer request / cancel
//  start_addr, len first ROM byte and byte count (0 = no transfer)
//  busy, done, err transfer in progress, end pulse, sticky timeout flag
//  rom_cs, rom_addr, rom_data, rom_ok   sample ROM port
//  drqn            chip data request, active low
//  cs, wrn, dout   chip select, write strobe (active low), data bus
module jt7759_feeder
    import jt7759_feeder_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int WR_W   = WR_W_DEF,
    parameter int TOUT_W = TOUT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    input  logic          drqn,
    output logic          cs,
    output logic          wrn,
    output logic [7:0]    dout
);

    localparam logic [3:0] WR_LAST = 4'(WR_W - 1);

    feed_state_t       st, st_nxt;
    logic              drqn_s;
    logic [AW-1:0]     cnt;
    logic [3:0]        wr_cnt;
    logic [TOUT_W-1:0] tout;
    logic [7:0]        buf_data;
    logic              buf_vld;
    logic              pop;
    logic              accept;
    logic              empty_req;
    logic              timeout;
    logic              finish;

    assign accept    = (st == ST_IDLE) && start && !abort && (len != '0);
    assign empty_req = (st == ST_IDLE) && start && !abort && (len == '0);
    assign timeout   = !abort && (st == ST_ACK) && cen && !drqn_s && (&tout);
    assign finish    = !abort && (st == ST_ACK) && cen && drqn_s && (cnt == '0);

    // Strobes come straight from the state register so abort releases them
    // on the very next cycle, even in the middle of PULSE.
    assign busy = (st != ST_IDLE);
    assign cs   = (st == ST_SETUP) || (st == ST_PULSE) || (st == ST_HOLD);
    assign wrn  = (st != ST_PULSE);

    jt7759_feeder_fetch #(
        .AW (AW)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .stop      (abort || timeout),
        .load_addr (start_addr),
        .load_len  (len),
        .pop       (pop),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rom_ok    (rom_ok),
        .buf_data  (buf_data),
        .buf_vld   (buf_vld)
    );

    always_comb begin
        st_nxt = st;
        pop    = 1'b0;
        if (abort) begin
            st_nxt = ST_IDLE;
        end else begin
            case (st)
                ST_IDLE:     if (start && (len != '0)) st_nxt = ST_FETCH;
                ST_FETCH:    if (cen) st_nxt = ST_WAIT_REQ;
                ST_WAIT_REQ: if (cen && buf_vld && !drqn_s) st_nxt = ST_SETUP;
                ST_SETUP:    if (cen) st_nxt = ST_PULSE;
                ST_PULSE:    if (cen && (wr_cnt == WR_LAST)) st_nxt = ST_HOLD;
                ST_HOLD: begin
                    if (cen) begin
                        st_nxt = ST_ACK;
                        pop    = 1'b1;
                    end
                end
                ST_ACK: begin
                    if (cen) begin
                        if (drqn_s)    st_nxt = (cnt == '0) ? ST_IDLE : ST_WAIT_REQ;
                        else if (&tout) st_nxt = ST_IDLE;
                    end
                end
                default:     st_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= ST_IDLE;
            drqn_s <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
            cnt    <= '0;
            wr_cnt <= '0;
            tout   <= '0;
            dout   <= '0;
        end else begin
            st     <= st_nxt;
            drqn_s <= drqn;
            done   <= empty_req || finish || timeout;
            if (timeout)     err <= 1'b1;
            else if (accept) err <= 1'b0;
            if (accept) cnt <= len;
            else if (pop && !abort) cnt <= cnt - 1'b1;
            if ((st == ST_WAIT_REQ) && (st_nxt == ST_SETUP)) dout <= buf_data;
            // Tick counters restart whenever their state is left.
            if (st != ST_PULSE) wr_cnt <= '0;
            else if (cen)       wr_cnt <= wr_cnt + 4'd1;
            if (st != ST_ACK)   tout <= '0;
            else if (cen)       tout <= tout + 1'b1;
        end
    end

endmodule

// File: tb/tb_jt7759_feeder.sv
// Bench for jt7759_feeder: ROM model (rom_ok after 3 stable clk, optional
// stale rom_ok injection) and a chip model that requests with drqn low and
// acknowledges each strobe by raising drqn for 8 clk. Expected bytes are
// queued at start and popped on every falling wrn edge with cs high.
module tb_jt7759_feeder;

    localparam int AW     = 17;
    localparam int WR_W   = 2;
    localparam int TOUT_W = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] len = '0;
    logic [7:0]    rom_data = 8'h00;
    logic          rom_ok = 1'b0;
    logic          drqn = 1'b0;
    logic          busy, done, err, rom_cs, cs, wrn;
    logic [AW-1:0] rom_addr;
    logic [7:0]    dout;

    int  n_tests = 0;
    int  n_fail  = 0;
    logic [7:0] exp_q[$];

    int  n_writes = 0;
    int  n_done   = 0;
    int  cyc_now  = 0;
    int  t_rise   = 0;
    int  hi_cnt   = 0;
    int  sc       = 0;
    bit  noack    = 0;
    bit  stale_en = 0;
    bit  saw_cs   = 0;
    bit  saw_rcs  = 0;
    bit  saw_busy = 0;
    logic          wrn_last  = 1'b1;
    logic          last_cs   = 1'b0;
    logic [AW-1:0] last_addr = '0;

    jt7759_feeder #(
        .AW     (AW),
        .WR_W   (WR_W),
        .TOUT_W (TOUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .drqn       (drqn),
        .cs         (cs),
        .wrn        (wrn),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        return a[7:0] + 8'hA0 + a[16:9];
    endfunction

    // ROM and chip models, all updates away from the active edge.
    always @(negedge clk) begin
        cyc_now++;
        cen = ~cen;
        if (rom_cs && last_cs && (rom_addr == last_addr)) begin
            if (sc < 3) sc++;
        end else begin
            sc = 0;
        end
        last_addr = rom_addr;
        last_cs   = rom_cs;
        rom_ok    = rom_cs && ((sc >= 3) || (stale_en && (sc < 2)));
        rom_data  = (sc >= 3) ? rom_byte(rom_addr) : 8'hEE;

        if (cs && wrn_last && !wrn) begin
            n_writes++;
            if (exp_q.size() == 0) check("extra_write", exp_q.size(), 1);
            else check("wr_data", dout, exp_q.pop_front());
        end
        if (!wrn_last && wrn) begin
            t_rise = cyc_now;
            if (!noack) hi_cnt = 8;
        end
        if (hi_cnt > 0) begin
            drqn = 1'b1;
            hi_cnt--;
        end else begin
            drqn = 1'b0;
        end
        wrn_last = wrn;
        if (done)   n_done++;
        if (cs)     saw_cs = 1;
        if (rom_cs) saw_rcs = 1;
        if (busy)   saw_busy = 1;
    end

    task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] l, input bit push);
        @(negedge clk);
        start_addr = a;
        len        = l;
        start      = 1'b1;
        if (push) begin
            for (int i = 0; i < int'(l); i++) begin
                logic [AW-1:0] ad;
                ad = a + AW'(i);
                exp_q.push_back(rom_byte(ad));
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int k;
        ok = 0;
        k  = 0;
        while (!ok && k < budget) begin
            @(negedge clk);
            k++;
            if (done) ok = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bit ok;
        int w0, d0, dt, k;

        repeat (4) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rom_cs", rom_cs, 0);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_cs", cs, 0);
        check("rst_wrn", wrn, 1);
        check("rst_dout", dout, 0);
        rst = 1'b0;
        idle(2);

        // 1) basic 4-byte stream
        w0 = n_writes;
        do_start(17'h00100, 17'd4, 1);
        wait_done(600, ok);
        check("t1_done_seen", ok, 1);
        check("t1_writes", n_writes - w0, 4);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_busy", busy, 0);
        check("t1_err", err, 0);
        idle(20);

        // 2) zero length
        saw_cs = 0; saw_rcs = 0; saw_busy = 0;
        do_start(17'h00050, 17'd0, 0);
        check("t2_done_pulse", done, 1);
        check("t2_busy", busy, 0);
        @(negedge clk);
        check("t2_done_clear", done, 0);
        idle(20);
        check("t2_no_cs", saw_cs, 0);
        check("t2_no_rom_cs", saw_rcs, 0);
        check("t2_no_busy", saw_busy, 0);

        // 3) no acknowledge -> timeout after 2^TOUT_W cen ticks
        noack = 1;
        w0 = n_writes;
        do_start(17'h00180, 17'd3, 1);
        wait_done(600, ok);
        dt = cyc_now - t_rise;
        check("t3_done_seen", ok, 1);
        check("t3_err", err, 1);
        check("t3_cs", cs, 0);
        check("t3_wrn", wrn, 1);
        check("t3_busy", busy, 0);
        check("t3_writes", n_writes - w0, 1);
        check("t3_tout_window", (dt >= 30 && dt <= 38), 1);
        @(negedge clk);
        check("t3_rom_idle", rom_cs, 0);
        exp_q.delete();
        noack = 0;
        idle(20);

        // 4) abort in the middle of PULSE, then a fresh transfer
        do_start(17'h00140, 17'd4, 1);
        check("t4_err_cleared", err, 0);
        k = 0;
        while (wrn !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("t4_pulse_seen", wrn, 0);
        d0 = n_done;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_wrn", wrn, 1);
        check("t4_cs", cs, 0);
        check("t4_busy", busy, 0);
        check("t4_rom_cs", rom_cs, 0);
        idle(20);
        check("t4_no_done", n_done - d0, 0);
        exp_q.delete();
        w0 = n_writes;
        do_start(17'h00200, 17'd3, 1);
        wait_done(600, ok);
        check("t4_done_seen", ok, 1);
        check("t4_writes", n_writes - w0, 3);
        check("t4_q_empty", exp_q.size(), 0);
        idle(20);

        // 5) address wrap with stale rom_ok
        stale_en = 1;
        w0 = n_writes;
        do_start(17'h1FFFF, 17'd2, 1);
        wait_done(600, ok);
        check("t5_done_seen", ok, 1);
        check("t5_writes", n_writes - w0, 2);
        check("t5_q_empty", exp_q.size(), 0);
        check("t5_rom_addr", rom_addr, 17'h00001);
        stale_en = 0;
        idle(20);

        // 6a) start while busy is ignored
        w0 = n_writes;
        do_start(17'h00300, 17'd3, 1);
        k = 0;
        while (wrn !== 1'b0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        do_start(17'h00400, 17'd5, 0);
        wait_done(600, ok);
        check("t6_done_seen", ok, 1);
        idle(40);
        check("t6_writes", n_writes - w0, 3);
        check("t6_q_empty", exp_q.size(), 0);
        check("t6_busy", busy, 0);

        // 6b) start and abort together in IDLE
        saw_rcs = 0; saw_busy = 0;
        d0 = n_done;
        w0 = n_writes;
        @(negedge clk);
        start_addr = 17'h00500;
        len        = 17'd2;
        start      = 1'b1;
        abort      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("t6b_busy", busy, 0);
        check("t6b_done", done, 0);
        idle(20);
        check("t6b_no_busy", saw_busy, 0);
        check("t6b_no_rom_cs", saw_rcs, 0);
        check("t6b_no_done", n_done - d0, 0);
        check("t6b_no_writes", n_writes - w0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
